// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Holds the FSM encoding, the channel count and the LED bit map.
package mux_rr_arbiter_pkg;

  localparam int N = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int LED_GRANT_LSB = 0;
  localparam int LED_SEL_LSB   = 4;
  localparam int LED_OUT       = 6;
  localparam int LED_VALID     = 7;
  localparam int LED_PTR_LSB   = 8;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: returns the first set mask bit
// starting at ptr and wrapping modulo 4, plus a flag if any bit is set.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N-1:0] mask,
  input  logic [1:0]   ptr,
  output logic [1:0]   idx,
  output logic         any
);

  logic [N-1:0] rot;

  // rot[k] is the request seen k places after ptr
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot[gi] = mask[2'(ptr + 2'(gi))];
  end

  always_comb begin
    idx = ptr;
    any = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = ptr + 2'(i);
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux line,
// with a minimum dwell per grant and status mirrored on the LED bank.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] in,
  output logic [1:0]   select,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         out,
  output logic [9:0]   LED
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    select_q, select_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;

  logic [N-1:0] owner_bit;
  logic [N-1:0] others;
  logic [N-1:0] pick_mask;
  logic [1:0]   pick_ptr;
  logic [1:0]   pick_idx;
  logic         pick_any;

  // In GRANT the picker only ever runs for a handover, so it always sees
  // the request set with the owner removed and starts just past the owner.
  always_comb begin
    owner_bit = N'(1) << select_q;
    others    = req & ~owner_bit;
    pick_mask = req;
    pick_ptr  = ptr_q;
    if (state_q == GRANT) begin
      pick_mask = others;
      pick_ptr  = select_q + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    select_d = select_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          select_d = pick_idx;
          grant_d  = N'(1) << pick_idx;
          valid_d  = 1'b1;
          count_d  = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!req[select_q] || (count_q == DWELL_M1 && |others)) begin
          ptr_d   = select_q + 2'd1;
          count_d = '0;
          if (pick_any) begin
            select_d = pick_idx;
            grant_d  = N'(1) << pick_idx;
            valid_d  = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (count_q != DWELL_M1) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      select_q <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      select_q <= select_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
    end
  end

  assign select = select_q;
  assign grant  = grant_q;
  assign valid  = valid_q;
  assign out    = valid_q & in[select_q];

  assign LED[LED_GRANT_LSB +: N] = grant_q;
  assign LED[LED_SEL_LSB +: 2]   = select_q;
  assign LED[LED_OUT]            = out;
  assign LED[LED_VALID]          = valid_q;
  assign LED[LED_PTR_LSB +: 2]   = ptr_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DWELL=4): contention rotation,
// early release, wrap-around, drain, single requester and reset mid-grant.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] in;
  logic [1:0] select;
  logic [3:0] grant;
  logic       valid;
  logic       out;
  logic [9:0] LED;

  int total;
  int bad;

  mux_rr_arbiter #(.DWELL(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .in     (in),
    .select (select),
    .grant  (grant),
    .valid  (valid),
    .out    (out),
    .LED    (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       exp_o;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    in    = 4'b0000;
    tick();
    tick();
    chk("rst_grant",  32'(grant),  32'h0);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_valid",  32'(valid),  32'h0);
    chk("rst_out",    32'(out),    32'h0);
    chk("rst_led",    32'(LED),    32'h0);
    reset = 1'b0;

    // full contention: each owner holds exactly 4 cycles, no gaps
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_g = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("contend_grant_%0d", k), 32'(grant), 32'(exp_g));
      chk($sformatf("contend_valid_%0d", k), 32'(valid), 32'h1);
    end
    chk("contend_ptr", 32'(LED[9:8]), 32'h0);

    // owner 0 drops; channel 1 takes over, then holds one more cycle
    req = 4'b1010;
    tick();
    chk("early_setup_grant", 32'(grant), 32'b0010);
    tick();
    chk("early_hold_grant", 32'(grant), 32'b0010);
    req = 4'b1000;
    tick();
    chk("early_grant", 32'(grant), 32'b1000);
    chk("early_ptr",   32'(LED[9:8]), 32'h2);
    chk("early_count", 32'(dut.count_q), 32'h0);

    // owner 3 releases with 0101 pending: ptr wraps to 0, channel 0 wins
    req = 4'b0101;
    tick();
    chk("wrap_grant", 32'(grant), 32'b0001);
    chk("wrap_ptr",   32'(LED[9:8]), 32'h0);

    req = 4'b0010;
    in  = 4'b0010;
    tick();
    chk("drain_setup_grant", 32'(grant), 32'b0010);
    chk("drain_setup_out",   32'(out),   32'h1);
    req = 4'b0000;
    tick();
    chk("drain_valid",  32'(valid),  32'h0);
    chk("drain_grant",  32'(grant),  32'h0);
    chk("drain_out",    32'(out),    32'h0);
    chk("drain_select", 32'(select), 32'h1);
    chk("drain_ptr",    32'(LED[9:8]), 32'h2);

    // single requester on channel 2, held; out tracks in[2] only
    in  = 4'b0000;
    req = 4'b0100;
    tick();
    chk("single_grant",  32'(grant),  32'b0100);
    chk("single_select", 32'(select), 32'h2);
    chk("single_valid",  32'(valid),  32'h1);
    for (int k = 0; k < 20; k++) begin
      in = (k % 2 == 1) ? 4'b0100 : 4'b1011;
      #1;
      exp_o = (k % 2 == 1);
      chk($sformatf("single_out_%0d", k),   32'(out),   32'(exp_o));
      chk($sformatf("single_led_%0d", k),   32'(LED),
          32'({2'd2, 1'b1, exp_o, 2'd2, 4'b0100}));
      tick();
      chk($sformatf("single_hold_%0d", k), 32'(grant), 32'b0100);
    end

    // reset mid-grant, then fresh request from reset state
    reset = 1'b1;
    in    = 4'b1111;
    tick();
    chk("midrst_grant",  32'(grant),  32'h0);
    chk("midrst_select", 32'(select), 32'h0);
    chk("midrst_valid",  32'(valid),  32'h0);
    chk("midrst_out",    32'(out),    32'h0);
    chk("midrst_led",    32'(LED),    32'h0);
    reset = 1'b0;
    req   = 4'b0001;
    tick();
    chk("post_rst_grant", 32'(grant), 32'b0001);
    chk("post_rst_valid", 32'(valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
